// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit RISC pipeline: ALU opcodes, instruction
// field positions and widths, register specifier width, and a helper that
// splits an instruction word into its fields.
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int INSTR_W    = 16;
  localparam int REG_ADDR_W = 3;
  localparam int IMM_W      = 7;
  localparam int OP_W       = 2;

  // Field positions (LSB of each field)
  localparam int OP_LSB  = 14;
  localparam int IMM_BIT = 13;
  localparam int RD_LSB  = 10;
  localparam int RS1_LSB = 7;
  localparam int RS2_LSB = 4;
  localparam int IMM_LSB = 0;

  // ALU opcodes
  localparam logic [OP_W-1:0] OP_ADD   = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB   = 2'b01;
  localparam logic [OP_W-1:0] OP_SHIFT = 2'b10;
  localparam logic [OP_W-1:0] OP_NAND  = 2'b11;

  typedef struct packed {
    logic [OP_W-1:0]       op;
    logic                  imm;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [IMM_W-1:0]      imm7;
  } instr_fields_t;

  // rs2 and imm7 overlap; the consumer picks one based on the imm bit.
  function automatic instr_fields_t decode_instr(input logic [INSTR_W-1:0] w);
    instr_fields_t f;
    f.op   = w[OP_LSB +: OP_W];
    f.imm  = w[IMM_BIT];
    f.rd   = w[RD_LSB +: REG_ADDR_W];
    f.rs1  = w[RS1_LSB +: REG_ADDR_W];
    f.rs2  = w[RS2_LSB +: REG_ADDR_W];
    f.imm7 = w[IMM_LSB +: IMM_W];
    return f;
  endfunction

endpackage

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// NUM_REGS x DATA_W register file, two combinational read ports, one write
// port. R0 always reads zero and ignores writes.
// Optional feature macro: DECODE_BYPASS_EN -- when defined, a write in the
// current cycle to a register being read is forwarded to the read port.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (clears all)
//   raddr1/rdata1         read port 1
//   raddr2/rdata2         read port 2
//   wen/waddr/wdata       write port, applied at the rising edge
// -----------------------------------------------------------------------------
module reg_file
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0]     rdata1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0]     rdata2,
  input  logic                  wen,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata
);

  logic [DATA_W-1:0] mem_r [NUM_REGS];

  // Storage update; entry 0 is never written so R0 stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wen && (waddr != '0)) begin
      mem_r[waddr] <= wdata;
    end else begin
      mem_r <= mem_r;
    end
  end

  // Read port 1 with R0 forced to zero and optional write forwarding.
  always_comb begin
    rdata1 = '0;
    if (raddr1 == '0) begin
      rdata1 = '0;
`ifdef DECODE_BYPASS_EN
    end else if (wen && (waddr == raddr1)) begin
      rdata1 = wdata;
`endif
    end else begin
      rdata1 = mem_r[raddr1];
    end
  end

  // Read port 2 with R0 forced to zero and optional write forwarding.
  always_comb begin
    rdata2 = '0;
    if (raddr2 == '0) begin
      rdata2 = '0;
`ifdef DECODE_BYPASS_EN
    end else if (wen && (waddr == raddr2)) begin
      rdata2 = wdata;
`endif
    end else begin
      rdata2 = mem_r[raddr2];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Decode and operand-fetch stage. Accepts instructions over valid/ready,
// reads operands from reg_file, tracks in-flight destinations with a
// one-bit-per-register scoreboard and stalls on RAW hazards, then presents
// op/a/b/rd to the ALU stage through a registered valid/ready output.
// Optional feature macro: DECODE_BYPASS_EN -- when defined, a write-back in
// the current cycle releases a hazard on that register immediately and its
// data is forwarded into the operands.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready/instr    instruction input handshake
//   out_valid/out_ready        registered output handshake to the ALU
//   op, a, b, rd               decoded opcode, operands, destination
//   wb_en/wb_addr/wb_data      write-back port from downstream
// -----------------------------------------------------------------------------
module decode_stage
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OP_W-1:0]       op,
  output logic [DATA_W-1:0]     a,
  output logic [DATA_W-1:0]     b,
  output logic [REG_ADDR_W-1:0] rd,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data
);

  instr_fields_t         fld_s;
  logic [DATA_W-1:0]     rdata1_s;
  logic [DATA_W-1:0]     rdata2_s;
  logic [DATA_W-1:0]     b_sel_s;
  logic [NUM_REGS-1:0]   pending_r;
  logic [NUM_REGS-1:0]   pending_nxt_s;
  logic [NUM_REGS-1:0]   wb_clr_s;
  logic [NUM_REGS-1:0]   pend_eff_s;
  logic                  hazard_s;
  logic                  in_ready_s;
  logic                  accept_s;

  logic                  out_valid_r;
  logic [OP_W-1:0]       op_r;
  logic [DATA_W-1:0]     a_r;
  logic [DATA_W-1:0]     b_r;
  logic [REG_ADDR_W-1:0] rd_r;

  assign fld_s = decode_instr(instr);

  reg_file #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_reg_file (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (fld_s.rs1),
    .rdata1 (rdata1_s),
    .raddr2 (fld_s.rs2),
    .rdata2 (rdata2_s),
    .wen    (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data)
  );

  // Operand B: zero-extended immediate or the second register read.
  always_comb begin
    b_sel_s = '0;
    if (fld_s.imm) begin
      b_sel_s = {{(DATA_W-IMM_W){1'b0}}, fld_s.imm7};
    end else begin
      b_sel_s = rdata2_s;
    end
  end

  // One-hot mask of the register being written back this cycle.
  always_comb begin
    wb_clr_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wb_clr_s[i] = wb_en && (wb_addr == REG_ADDR_W'(i));
    end
  end

  // Pending view used for hazard detection; with bypass, a register being
  // written back right now is already considered available.
  always_comb begin
`ifdef DECODE_BYPASS_EN
    pend_eff_s = pending_r & ~wb_clr_s;
`else
    pend_eff_s = pending_r;
`endif
  end

  // RAW hazard, handshake ready and accept.
  always_comb begin
    hazard_s   = in_valid &&
                 (pend_eff_s[fld_s.rs1] || (!fld_s.imm && pend_eff_s[fld_s.rs2]));
    in_ready_s = (!out_valid_r || out_ready) && !hazard_s;
    accept_s   = in_valid && in_ready_s;
  end

  // Scoreboard next state: set on accept beats clear on write-back; R0 never pending.
  always_comb begin
    pending_nxt_s = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      pending_nxt_s[i] = (accept_s && (fld_s.rd == REG_ADDR_W'(i))) ? 1'b1 :
                         wb_clr_s[i] ? 1'b0 : pending_r[i];
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= '0;
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // Output register: load on accept, drop valid on drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      op_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      rd_r        <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      op_r        <= fld_s.op;
      a_r         <= rdata1_s;
      b_r         <= b_sel_s;
      rd_r        <= fld_s.rd;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign op        = op_r;
  assign a         = a_r;
  assign b         = b_r;
  assign rd        = rd_r;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  typedef struct packed {
    logic [15:0] instr;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  rd;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t exp_q[$];
  vec_t cur_exp;
  vec_t vecs[6];
  logic [15:0] pre[8];

  always #5 clk = ~clk;

  decode_stage #(.NUM_REGS(8), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .a(a), .b(b), .rd(rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  function automatic logic [15:0] enc_r(input logic [1:0] o, input logic [2:0] d,
                                        input logic [2:0] s1, input logic [2:0] s2,
                                        input logic [3:0] junk);
    return {o, 1'b0, d, s1, s2, junk};
  endfunction

  function automatic logic [15:0] enc_i(input logic [1:0] o, input logic [2:0] d,
                                        input logic [2:0] s1, input logic [6:0] imm);
    return {o, 1'b1, d, s1, imm};
  endfunction

  function automatic vec_t mk(input logic [15:0] i, input logic [1:0] o,
                              input logic [15:0] ea, input logic [15:0] eb,
                              input logic [2:0] ed);
    vec_t v;
    v.instr = i; v.op = o; v.a = ea; v.b = eb; v.rd = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic present(input vec_t v);
    in_valid = 1'b1;
    instr    = v.instr;
    cur_exp  = v;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    instr    = 16'h0000;
  endtask

  task automatic wb(input logic en, input logic [2:0] ad, input logic [15:0] d);
    wb_en   = en;
    wb_addr = ad;
    wb_data = d;
  endtask

  task automatic chk_ready(input string name, input logic e);
    #1;
    chk(name, {63'd0, in_ready}, {63'd0, e});
  endtask

  // One clock: record an accept in the scoreboard, then check the output it produced.
  task automatic cycle(input string tag);
    logic acc;
    vec_t e;
    #1;
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(cur_exp);
    @(posedge clk);
    #1;
    if (acc) begin
      if (exp_q.size() == 0) begin
        chk({tag, " scoreboard"}, 64'd0, 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk({tag, " valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, " op/a/b/rd"}, {27'd0, op, a, b, rd}, {27'd0, e.op, e.a, e.b, e.rd});
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t x, y;
    rst_n = 1'b0; out_ready = 1'b1;
    idle();
    wb(1'b0, 3'd0, 16'h0000);
    pre[0] = 16'h0000; pre[1] = 16'h0001; pre[2] = 16'h0004; pre[3] = 16'h0003;
    pre[4] = 16'h00F0; pre[5] = 16'hFFFF; pre[6] = 16'h8000; pre[7] = 16'h1234;

    vecs[0] = mk(16'h0530,                        2'd0, 16'h0004, 16'h0003, 3'd1);
    vecs[1] = mk(enc_r(2'd1, 3'd6, 3'd5, 3'd4, 4'h0), 2'd1, 16'hFFFF, 16'h00F0, 3'd6);
    vecs[2] = mk(enc_i(2'd2, 3'd2, 3'd7, 7'h7F),      2'd2, 16'h1234, 16'h007F, 3'd2);
    vecs[3] = mk(enc_r(2'd3, 3'd7, 3'd6, 3'd5, 4'hA), 2'd3, 16'h8000, 16'hFFFF, 3'd7);
    vecs[4] = mk(enc_i(2'd0, 3'd3, 3'd0, 7'h40),      2'd0, 16'h0000, 16'h0040, 3'd3);
    vecs[5] = mk(enc_r(2'd1, 3'd5, 3'd3, 3'd0, 4'h0), 2'd1, 16'h0003, 16'h0000, 3'd5);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset outputs", {27'd0, op, a, b, rd}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_ready("ready after reset", 1'b1);

    // Preload R1..R7
    for (int i = 1; i < 8; i++) begin
      wb(1'b1, 3'(i), pre[i]);
      cycle("preload");
    end
    wb(1'b0, 3'd0, 16'h0000);

    // Table: each instruction, then restore its rd to clear the pending bit
    for (int i = 0; i < 6; i++) begin
      present(vecs[i]);
      chk_ready("table ready", 1'b1);
      cycle("table");
      idle();
      wb(1'b1, vecs[i].rd, pre[vecs[i].rd]);
      cycle("restore");
      wb(1'b0, 3'd0, 16'h0000);
    end

    // Hazard stall on R1
    present(mk(16'h2405, 2'd0, 16'h0000, 16'h0005, 3'd1));
    chk_ready("addi ready", 1'b1);
    cycle("addi");
    present(mk(16'h5090, 2'd1, 16'h0005, 16'h0005, 3'd4));
    chk_ready("hazard stall 1", 1'b0);
    cycle("stall");
    chk_ready("hazard stall 2", 1'b0);
    cycle("stall");
    wb(1'b1, 3'd1, 16'h0005);
`ifdef DECODE_BYPASS_EN
    chk_ready("bypass release", 1'b1);
    cycle("sub bypass");
    wb(1'b0, 3'd0, 16'h0000);
`else
    chk_ready("wb cycle still stalled", 1'b0);
    cycle("stall wb");
    wb(1'b0, 3'd0, 16'h0000);
    chk_ready("release after wb", 1'b1);
    cycle("sub");
`endif
    idle();
    wb(1'b1, 3'd4, 16'h00F0);
    cycle("restore r4");
    wb(1'b0, 3'd0, 16'h0000);

    // Backpressure
    x = mk(enc_r(2'd0, 3'd2, 3'd2, 3'd3, 4'h0), 2'd0, 16'h0004, 16'h0003, 3'd2);
    y = mk(enc_r(2'd3, 3'd3, 3'd7, 3'd6, 4'h0), 2'd3, 16'h1234, 16'h8000, 3'd3);
    present(x);
    chk_ready("bp first ready", 1'b1);
    cycle("bp first");
    out_ready = 1'b0;
    present(y);
    for (int k = 0; k < 3; k++) begin
      chk_ready("bp blocked", 1'b0);
      cycle("bp hold");
      chk("bp valid held", {63'd0, out_valid}, 64'd1);
      chk("bp data held", {27'd0, op, a, b, rd}, {27'd0, x.op, x.a, x.b, x.rd});
    end
    out_ready = 1'b1;
    chk_ready("bp release", 1'b1);
    cycle("bp second");
    idle();
    wb(1'b1, 3'd2, 16'h0004);
    cycle("restore r2");
    wb(1'b1, 3'd3, 16'h0003);
    cycle("restore r3");
    wb(1'b0, 3'd0, 16'h0000);

    // R0 write dropped, R0 never pending
    wb(1'b1, 3'd0, 16'hFFFF);
    cycle("wb r0");
    wb(1'b0, 3'd0, 16'h0000);
    present(mk(16'h0000, 2'd0, 16'h0000, 16'h0000, 3'd0));
    chk_ready("r0 ready", 1'b1);
    cycle("r0 read");
    chk_ready("r0 no stall", 1'b1);
    cycle("r0 again");
    idle();

    // Set/clear collision on R1: set wins
    present(mk(enc_i(2'd0, 3'd1, 3'd0, 7'h09), 2'd0, 16'h0000, 16'h0009, 3'd1));
    wb(1'b1, 3'd1, 16'h0007);
    chk_ready("collision accept", 1'b1);
    cycle("collision");
    wb(1'b0, 3'd0, 16'h0000);
    present(mk(enc_r(2'd0, 3'd2, 3'd1, 3'd0, 4'h0), 2'd0, 16'h0007, 16'h0000, 3'd2));
    chk_ready("collision stall 1", 1'b0);
    cycle("coll stall");
    chk_ready("collision stall 2", 1'b0);
    cycle("coll stall");

    // Reset with output held and hazard active
    out_ready = 1'b0;
    present(mk(enc_i(2'd2, 3'd0, 3'd0, 7'h01), 2'd2, 16'h0000, 16'h0001, 3'd0));
    chk_ready("filler ready", 1'b1);
    cycle("filler");
    present(mk(enc_r(2'd0, 3'd2, 3'd1, 3'd0, 4'h0), 2'd0, 16'h0000, 16'h0000, 3'd2));
    chk_ready("pre-reset stalled", 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid reset outputs", {27'd0, op, a, b, rd}, 64'd0);
    chk("mid reset ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk_ready("post reset ready", 1'b1);
    cycle("post reset read");
    idle();
    wb(1'b1, 3'd1, 16'h00AB);
    cycle("wb after reset");
    wb(1'b0, 3'd0, 16'h0000);
    present(mk(enc_i(2'd1, 3'd3, 3'd1, 7'h01), 2'd1, 16'h00AB, 16'h0001, 3'd3));
    chk_ready("read after reset wb ready", 1'b1);
    cycle("read after reset wb");
    idle();
    cycle("drain");

    chk("scoreboard empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
